// File: rtl/knn_seq_if.sv
// Handshake and reference-write bundle for knn_seq.
// master drives queries, reference writes and result acceptance; slave is the classifier.
interface knn_seq_if #(
    parameter int DATA_DIM        = 2,
    parameter int DIM_PREC        = 4,
    parameter int REF_DATA_POINTS = 8,
    parameter int CLASSIFICATIONS = 4
) ();
    localparam int CLS_W  = $clog2(CLASSIFICATIONS);
    localparam int PT_W   = DATA_DIM * DIM_PREC;
    localparam int DIST_W = 2 * DIM_PREC + $clog2(DATA_DIM) + 1;
    localparam int ADDR_W = $clog2(REF_DATA_POINTS);

    logic                  ref_we;
    logic [ADDR_W-1:0]     ref_addr;
    logic [CLS_W+PT_W-1:0] ref_wdata;
    logic                  q_valid;
    logic                  q_ready;
    logic [PT_W-1:0]       q_data;
    logic                  res_valid;
    logic                  res_ready;
    logic [CLS_W-1:0]      res_class;
    logic [DIST_W-1:0]     res_dist;
    logic                  busy;

    modport master (
        output ref_we, ref_addr, ref_wdata, q_valid, q_data, res_ready,
        input  q_ready, res_valid, res_class, res_dist, busy
    );

    modport slave (
        input  ref_we, ref_addr, ref_wdata, q_valid, q_data, res_ready,
        output q_ready, res_valid, res_class, res_dist, busy
    );
endinterface

// File: rtl/knn_seq.sv
// Sequential k-nearest-neighbour classifier: scans the reference memory, keeps a sorted K list, votes.
// Define KNN_MANHATTAN_EN to use sum of absolute differences instead of squared Euclidean distance.
//
// state | meaning
// IDLE  | accepting queries and reference writes
// SCAN  | one reference fetched per cycle, previous candidate inserted into the K list
// VOTE  | class c counted in cycle c, running maximum kept
// OUT   | result presented until res_ready
module knn_seq #(
    parameter int DATA_DIM        = 2,
    parameter int DIM_PREC        = 4,
    parameter int REF_DATA_POINTS = 8,
    parameter int K               = 3,
    parameter int CLASSIFICATIONS = 4
) (
    input logic      clk,
    input logic      reset,
    knn_seq_if.slave bus
);
    localparam int CLS_W  = $clog2(CLASSIFICATIONS);
    localparam int PT_W   = DATA_DIM * DIM_PREC;
    localparam int DIST_W = 2 * DIM_PREC + $clog2(DATA_DIM) + 1;
    localparam int IDX_W  = $clog2(REF_DATA_POINTS);
    localparam int CNT_W  = $clog2(K + 1);
    localparam int WORD_W = CLS_W + PT_W;

    typedef enum logic [1:0] {IDLE, SCAN, VOTE, OUT} state_t;

    state_t state_q, state_d;

    logic [WORD_W-1:0] mem_q [REF_DATA_POINTS];
    logic [PT_W-1:0]   query_q;
    logic [IDX_W-1:0]  idx_q;
    logic              fetch_done_q;
    logic              cand_vld_q;
    logic [DIST_W-1:0] cand_dist_q;
    logic [CLS_W-1:0]  cand_cls_q;
    logic [DIST_W-1:0] list_dist_q [K];
    logic [CLS_W-1:0]  list_cls_q  [K];
    logic              list_vld_q  [K];
    logic [CLS_W-1:0]  vote_idx_q;
    logic [CNT_W-1:0]  best_cnt_q;
    logic [CLS_W-1:0]  best_cls_q;
    logic [CLS_W-1:0]  res_class_q;
    logic [DIST_W-1:0] res_dist_q;

    logic [WORD_W-1:0]   ref_word;
    logic [DIM_PREC-1:0] diff;
    logic [DIST_W-1:0]   ref_dist;
    logic [K-1:0]        closer;
    logic [DIST_W-1:0]   ins_dist [K];
    logic [CLS_W-1:0]    ins_cls  [K];
    logic                ins_vld  [K];
    logic [CNT_W-1:0]    vote_cnt;
    logic [CNT_W-1:0]    new_best_cnt;
    logic [CLS_W-1:0]    new_best_cls;
    logic                last_fetch;
    logic                last_vote;

    assign ref_word   = mem_q[idx_q];
    assign last_fetch = (idx_q == IDX_W'(REF_DATA_POINTS - 1));
    assign last_vote  = (vote_idx_q == CLS_W'(CLASSIFICATIONS - 1));

    always_comb begin
        ref_dist = '0;
        diff     = '0;
        for (int d = 0; d < DATA_DIM; d++) begin
            diff = (query_q[d*DIM_PREC +: DIM_PREC] >= ref_word[d*DIM_PREC +: DIM_PREC])
                 ? query_q[d*DIM_PREC +: DIM_PREC] - ref_word[d*DIM_PREC +: DIM_PREC]
                 : ref_word[d*DIM_PREC +: DIM_PREC] - query_q[d*DIM_PREC +: DIM_PREC];
`ifdef KNN_MANHATTAN_EN
            ref_dist = ref_dist + DIST_W'(diff);
`else
            ref_dist = ref_dist + DIST_W'(diff) * DIST_W'(diff);
`endif
        end
    end

    // Strict compare: an equal-distance later reference never displaces an earlier one.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            closer[i]   = (cand_dist_q < list_dist_q[i]);
            ins_dist[i] = list_dist_q[i];
            ins_cls[i]  = list_cls_q[i];
            ins_vld[i]  = list_vld_q[i];
        end
        if (closer[0]) begin
            ins_dist[0] = cand_dist_q;
            ins_cls[0]  = cand_cls_q;
            ins_vld[0]  = 1'b1;
        end
        for (int i = 1; i < K; i++) begin
            if (closer[i-1]) begin
                ins_dist[i] = list_dist_q[i-1];
                ins_cls[i]  = list_cls_q[i-1];
                ins_vld[i]  = list_vld_q[i-1];
            end else if (closer[i]) begin
                ins_dist[i] = cand_dist_q;
                ins_cls[i]  = cand_cls_q;
                ins_vld[i]  = 1'b1;
            end
        end
    end

    always_comb begin
        vote_cnt = '0;
        for (int i = 0; i < K; i++) begin
            if (list_vld_q[i] && (list_cls_q[i] == vote_idx_q)) begin
                vote_cnt = vote_cnt + CNT_W'(1);
            end
        end
        new_best_cnt = best_cnt_q;
        new_best_cls = best_cls_q;
        if (vote_cnt > best_cnt_q) begin
            new_best_cnt = vote_cnt;
            new_best_cls = vote_idx_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.q_valid)   state_d = SCAN;
            SCAN:    if (fetch_done_q)  state_d = VOTE;
            VOTE:    if (last_vote)     state_d = OUT;
            OUT:     if (bus.res_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (bus.ref_we && (state_q == IDLE)) begin
            mem_q[bus.ref_addr] <= bus.ref_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            query_q      <= '0;
            idx_q        <= '0;
            fetch_done_q <= 1'b0;
            cand_vld_q   <= 1'b0;
            cand_dist_q  <= '0;
            cand_cls_q   <= '0;
            vote_idx_q   <= '0;
            best_cnt_q   <= '0;
            best_cls_q   <= '0;
            res_class_q  <= '0;
            res_dist_q   <= '0;
            for (int i = 0; i < K; i++) begin
                list_dist_q[i] <= '0;
                list_cls_q[i]  <= '0;
                list_vld_q[i]  <= 1'b0;
            end
        end else begin
            cand_vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.q_valid) begin
                        query_q      <= bus.q_data;
                        idx_q        <= '0;
                        fetch_done_q <= 1'b0;
                        vote_idx_q   <= '0;
                        best_cnt_q   <= '0;
                        best_cls_q   <= '0;
                        for (int i = 0; i < K; i++) begin
                            list_dist_q[i] <= '1;
                            list_cls_q[i]  <= '0;
                            list_vld_q[i]  <= 1'b0;
                        end
                    end
                end
                SCAN: begin
                    if (!fetch_done_q) begin
                        cand_dist_q <= ref_dist;
                        cand_cls_q  <= ref_word[WORD_W-1 -: CLS_W];
                        cand_vld_q  <= 1'b1;
                        if (last_fetch) fetch_done_q <= 1'b1;
                        else            idx_q        <= idx_q + 1'b1;
                    end
                    if (cand_vld_q) begin
                        for (int i = 0; i < K; i++) begin
                            list_dist_q[i] <= ins_dist[i];
                            list_cls_q[i]  <= ins_cls[i];
                            list_vld_q[i]  <= ins_vld[i];
                        end
                    end
                end
                VOTE: begin
                    best_cnt_q <= new_best_cnt;
                    best_cls_q <= new_best_cls;
                    vote_idx_q <= vote_idx_q + 1'b1;
                    if (last_vote) begin
                        res_class_q <= new_best_cls;
                        res_dist_q  <= list_dist_q[0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.q_ready   = (state_q == IDLE) && !reset;
    assign bus.busy      = (state_q != IDLE);
    assign bus.res_valid = (state_q == OUT);
    assign bus.res_class = res_class_q;
    assign bus.res_dist  = res_dist_q;
endmodule

// File: doc/knn_seq.md
KNN_SEQ -- requirements
Module: knn_seq

Interface
REQ-001 Parameter DATA_DIM, default 2: dimensions per data point.
REQ-002 Parameter DIM_PREC, default 4: unsigned bits per dimension.
REQ-003 Parameter REF_DATA_POINTS, default 8: reference memory depth; must be at least 2.
REQ-004 Parameter K, default 3: neighbours voted; must satisfy 1 <= K <= REF_DATA_POINTS.
REQ-005 Parameter CLASSIFICATIONS, default 4: number of classes; must be at least 2.
REQ-006 Derived widths: CLS_W=$clog2(CLASSIFICATIONS), PT_W=DATA_DIM*DIM_PREC, DIST_W=2*DIM_PREC+$clog2(DATA_DIM)+1.
REQ-007 Clock and reset: one clock; reset is synchronous and active-high; ports are named clk and reset.
REQ-008 clk  input  1  sole clock; all state updates on its rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 ref_we  input  1  reference memory write strobe.
REQ-011 ref_addr  input  $clog2(REF_DATA_POINTS)  reference write address.
REQ-012 ref_wdata  input  CLS_W+PT_W  {class, point} reference word, with the class in the MSBs.
REQ-013 q_valid  input  1  query offered.
REQ-014 q_ready  output  1  query accepted when q_valid and q_ready are both high.
REQ-015 q_data  input  PT_W  query point; dimension d occupies bits [d*DIM_PREC +: DIM_PREC].
REQ-016 res_valid  output  1  result available.
REQ-017 res_ready  input  1  result consumed when res_valid and res_ready are both high.
REQ-018 res_class  output  CLS_W  majority class.
REQ-019 res_dist  output  DIST_W  distance to the nearest reference point.
REQ-020 busy  output  1  high in every state except IDLE.

Function
REQ-021 The state machine SHALL have four states, IDLE, SCAN, VOTE and OUT, with transitions as follows.
- IDLE to SCAN on query handshake.
- SCAN to VOTE after the REF_DATA_POINTS-th reference.
- VOTE to OUT after CLASSIFICATIONS cycles.
- OUT to IDLE on result handshake.
REQ-022 q_ready SHALL equal 1 exactly in IDLE and be low while reset is asserted.
REQ-023 On accept, the block SHALL latch q_data, set all K list entries to distance all-ones with an invalid flag, and zero the reference index.
REQ-024 SCAN SHALL process one reference per cycle, in index order 0..REF_DATA_POINTS-1.
REQ-025 Distance SHALL be the sum of squared per-dimension differences, computed at DIST_W bits with no overflow.
REQ-026 The K list SHALL stay sorted ascending by distance.
- A candidate is inserted only if its distance is strictly less than the entry it displaces, and the last entry drops out.
- On equal distances, the lower reference index ranks nearer.
REQ-027 VOTE SHALL count class c in cycle c over the valid K entries and keep a running maximum.
- Ties resolve to the lower class index.
REQ-028 Latency: with the query accepted at edge T, res_valid SHALL rise after edge T+REF_DATA_POINTS+CLASSIFICATIONS+1.
REQ-029 res_class and res_dist SHALL hold stable while res_valid is high and res_ready is low.
REQ-030 A result handshake SHALL return the block to IDLE; q_ready is high in the following cycle, so there is no back-to-back accept in that same cycle.
REQ-031 ref_we SHALL write memory only in IDLE.
- ref_we in any other state is ignored.
- A write and a query accept in the same IDLE cycle both take effect, and the scan sees the new word.
REQ-032 Reference memory contents SHALL be undefined until written and SHALL NOT be cleared by reset.

Reset
REQ-033 Reset SHALL force IDLE and set q_ready=0 while asserted, busy=0, res_valid=0, res_class=0, res_dist=0, and clear the K list and vote counters.
REQ-034 Reset asserted during SCAN, VOTE or OUT SHALL abort the query without producing a result.
REQ-035 q_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-036 Macro KNN_MANHATTAN_EN, when defined, SHALL replace squared distance with the sum of absolute per-dimension differences.
- DIST_W, latency, tie rules and ports are unchanged.
- When the macro is not defined, distance is squared Euclidean per REQ-025.

Verification (DATA_DIM=2, DIM_PREC=4, REF_DATA_POINTS=8, K=3, CLASSIFICATIONS=4)
REQ-037 The bench SHALL cover basic classification.
- Stimulus: refs 0..7 = (i,i), with class 1 for i<4 and class 2 otherwise; query (1,1).
- Response: res_class=1 and res_dist=0, with res_valid rising 13 cycles after accept.
REQ-038 The bench SHALL cover vote tie.
- Stimulus: K=2; refs (0,0) class 3 and (1,0) class 0, all other refs at (15,15) class 2; query (0,0).
- Response: res_class=0, because ties resolve to the lower class index.
REQ-039 The bench SHALL cover backpressure.
- Stimulus: res_ready held at 0 for 5 cycles.
- Response: res_valid, res_class and res_dist stay stable, q_ready stays 0, and IDLE is reached only after the handshake.
REQ-040 The bench SHALL cover reset mid-SCAN.
- Stimulus: reset pulsed at SCAN index 4.
- Response: no res_valid, q_ready=1 on the cycle after release, and a new query completes correctly.
REQ-041 The bench SHALL cover the write guard.
- Stimulus: ref_we asserted to address 0 during SCAN.
- Response: the memory word is unchanged, and the result matches the pre-write data.
REQ-042 The bench SHALL cover KNN_MANHATTAN_EN.
- Stimulus: with the macro defined, ref (3,4) and query (0,0).
- Response: res_dist=7; without the macro, res_dist=25.
